// File: rtl/io_tile_top_param.sv
// io_tile_top_param: kFPGA fabric-edge IO tile.
// A serial configuration chain with a frame counter, plus a configurable
// crossbar between IO pads and interconnect tracks.
// Optional feature macro: KFPGA_IO_TILE_SHADOW_EN
//   defined   -> a separate shadow register applies a frame atomically on commit
//   undefined -> the datapath follows the shift register directly; commit ignored
module io_tile_top_param #(
  parameter int unsigned IO_COUNT = 4,
  parameter int unsigned IC_WIDTH = 10
) (
  input  logic                config_clock,
  input  logic                config_nreset,
  input  logic                config_in,
  output logic                config_out,
  input  logic                config_enable,
  input  logic                config_commit,
  output logic                config_loaded,
  output logic                config_error,
  input  logic [IO_COUNT-1:0] data_from_io,
  output logic [IO_COUNT-1:0] data_to_io,
  input  logic [IC_WIDTH-1:0] data_from_ic,
  output logic [IC_WIDTH-1:0] data_to_ic
);

  localparam int unsigned SEL_IC   = (IC_WIDTH > 1) ? $clog2(IC_WIDTH) : 1;
  localparam int unsigned SEL_IO   = (IO_COUNT > 1) ? $clog2(IO_COUNT) : 1;
  localparam int unsigned PAD_FW   = SEL_IC + 1;
  localparam int unsigned TRK_FW   = SEL_IO + 1;
  localparam int unsigned TRK_BASE = IO_COUNT * PAD_FW;
  localparam int unsigned CW       = TRK_BASE + IC_WIDTH * TRK_FW;
  localparam int unsigned CNT_W    = $clog2(CW + 1);

  logic [CW-1:0]    sr;
  logic [CW-1:0]    act;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             loaded_c;
  logic             commit_ok_c;

  assign loaded_c      = (cnt == CNT_W'(CW));
  assign config_loaded = loaded_c;
  assign config_out    = sr[CW-1];

  // Configuration shift register; first bit in travels to the MSB.
  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      sr <= '0;
    end else if (config_enable) begin
      sr <= {sr[CW-2:0], config_in};
    end
  end

  // Frame bit counter: saturates at CW, restarts on an accepted commit.
  always_comb begin
    cnt_nxt = cnt;
    if (config_enable && !loaded_c) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    if (commit_ok_c) begin
      cnt_nxt = config_enable ? CNT_W'(1) : CNT_W'(0);
    end
  end

  // Counter state register.
  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

`ifdef KFPGA_IO_TILE_SHADOW_EN
  assign commit_ok_c = config_commit && loaded_c;

  // Shadow register captures the pre-shift frame on an accepted commit.
  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      act <= '0;
    end else if (commit_ok_c) begin
      act <= sr;
    end
  end

  // Sticky flag for a commit requested before a full frame was loaded.
  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      config_error <= 1'b0;
    end else if (config_commit && !loaded_c) begin
      config_error <= 1'b1;
    end
  end
`else
  logic unused_commit;

  // Without a shadow the crossbar is driven straight from the chain.
  assign act           = sr;
  assign commit_ok_c   = 1'b0;
  assign config_error  = 1'b0;
  assign unused_commit = config_commit;
`endif

  // Pad outputs: each pad selects one track; disabled or out-of-range gives 0.
  for (genvar i = 0; i < int'(IO_COUNT); i++) begin : g_pad
    localparam int unsigned BASE = i * PAD_FW;
    logic              en;
    logic [SEL_IC-1:0] sel;
    assign en            = act[BASE];
    assign sel           = act[BASE+1 +: SEL_IC];
    assign data_to_io[i] = (en && (32'(sel) < IC_WIDTH)) ? data_from_ic[sel] : 1'b0;
  end

  // Track outputs: each track selects one pad; disabled or out-of-range gives 0.
  for (genvar j = 0; j < int'(IC_WIDTH); j++) begin : g_trk
    localparam int unsigned BASE = TRK_BASE + j * TRK_FW;
    logic              en;
    logic [SEL_IO-1:0] sel;
    assign en            = act[BASE];
    assign sel           = act[BASE+1 +: SEL_IO];
    assign data_to_ic[j] = (en && (32'(sel) < IO_COUNT)) ? data_from_io[sel] : 1'b0;
  end

endmodule

// File: tb/tb_io_tile_top_param.sv
// Directed bench for io_tile_top_param at default parameters (CW = 50).
// Expectations follow KFPGA_IO_TILE_SHADOW_EN as seen by this compile.
module tb_io_tile_top_param;

  localparam int unsigned CW = 50;
`ifdef KFPGA_IO_TILE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // Pad 2 = {sel=7, en=1}: bits 10..13 set.
  localparam logic [CW-1:0] F_PAD = 50'h0_0000_0000_3C00;
  // Track 9 = {sel=3, en=1}, track 0 = {sel=3, en=0}, pad 0 = {sel=12, en=1}.
  localparam logic [CW-1:0] F_TRK = 50'h3_8000_0060_0019;

  logic       config_clock;
  logic       config_nreset;
  logic       config_in;
  logic       config_out;
  logic       config_enable;
  logic       config_commit;
  logic       config_loaded;
  logic       config_error;
  logic [3:0] data_from_io;
  logic [3:0] data_to_io;
  logic [9:0] data_from_ic;
  logic [9:0] data_to_ic;

  int checks;
  int errors;

  io_tile_top_param #(.IO_COUNT(4), .IC_WIDTH(10)) dut (
    .config_clock (config_clock),
    .config_nreset(config_nreset),
    .config_in    (config_in),
    .config_out   (config_out),
    .config_enable(config_enable),
    .config_commit(config_commit),
    .config_loaded(config_loaded),
    .config_error (config_error),
    .data_from_io (data_from_io),
    .data_to_io   (data_to_io),
    .data_from_ic (data_from_ic),
    .data_to_ic   (data_to_ic)
  );

  initial config_clock = 1'b0;
  always #5 config_clock = ~config_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic shift(input logic b);
    config_in     = b;
    config_enable = 1'b1;
    @(posedge config_clock);
    #1;
    config_enable = 1'b0;
  endtask

  task automatic shift_frame(input logic [CW-1:0] f, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) shift(f[k]);
  endtask

  task automatic commit();
    config_commit = 1'b1;
    @(posedge config_clock);
    #1;
    config_commit = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic       pb [100];
    checks        = 0;
    errors        = 0;
    config_nreset = 1'b0;
    config_in     = 1'b0;
    config_enable = 1'b0;
    config_commit = 1'b0;
    data_from_io  = 4'hF;
    data_from_ic  = 10'h3FF;
    #12;
    check("rst_out", 32'(config_out), 32'd0);
    check("rst_loaded", 32'(config_loaded), 32'd0);
    check("rst_dio", 32'(data_to_io), 32'd0);
    check("rst_dic", 32'(data_to_ic), 32'd0);
    config_nreset = 1'b1;

    // Random traffic, then asynchronous reset between clock edges.
    for (int i = 0; i < 60; i++) begin
      data_from_io = 4'($urandom);
      data_from_ic = 10'($urandom);
      shift(1'($urandom_range(0, 1)));
    end
    commit();
    for (int i = 0; i < 7; i++) shift(1'($urandom_range(0, 1)));
    #2;
    config_nreset = 1'b0;
    #1;
    check("arst_out", 32'(config_out), 32'd0);
    check("arst_loaded", 32'(config_loaded), 32'd0);
    check("arst_error", 32'(config_error), 32'd0);
    check("arst_dio", 32'(data_to_io), 32'd0);
    check("arst_dic", 32'(data_to_ic), 32'd0);
    #3;
    config_nreset = 1'b1;
    data_from_ic  = 10'h080;
    data_from_io  = 4'b1000;

    // Pad route; 49 shifts not yet loaded, 50th loaded.
    shift_frame(F_PAD, CW - 1, 1);
    check("loaded_49", 32'(config_loaded), 32'd0);
    shift_frame(F_PAD, 0, 0);
    check("loaded_50", 32'(config_loaded), 32'd1);
    check("pad_precommit", 32'(data_to_io), SHADOW ? 32'h0 : 32'h4);
    commit();
    check("pad_route", 32'(data_to_io), 32'h4);
    check("pad_loaded", 32'(config_loaded), SHADOW ? 32'd0 : 32'd1);
    check("pad_error", 32'(config_error), 32'd0);

    // Track route and out-of-range pad select.
    shift_frame(F_TRK, CW - 1, 0);
    check("trk_loaded", 32'(config_loaded), 32'd1);
    commit();
    check("trk_route", 32'(data_to_ic), 32'h200);
    data_from_io = 4'b0111;
    #1;
    check("trk_other", 32'(data_to_ic), 32'h0);
    data_from_ic = 10'h3FF;
    #1;
    check("pad_oor_ones", 32'(data_to_io), 32'h0);
    data_from_ic = 10'h080;
    data_from_io = 4'b1000;
    #1;
    check("pad_oor_080", 32'(data_to_io), 32'h0);

    // Early commit after 20 shifts.
    shift_frame(F_PAD, CW - 1, 30);
    commit();
    check("early_error", 32'(config_error), SHADOW ? 32'd1 : 32'd0);
    check("early_loaded", 32'(config_loaded), SHADOW ? 32'd0 : 32'd1);
    if (SHADOW) check("early_hold", 32'(data_to_ic), 32'h200);
    shift_frame(F_PAD, 29, 1);
    check("early_49", 32'(config_loaded), SHADOW ? 32'd0 : 32'd1);
    shift_frame(F_PAD, 0, 0);
    check("early_50", 32'(config_loaded), 32'd1);
    check("early_dio", 32'(data_to_io), SHADOW ? 32'h0 : 32'h4);

    // Commit and shift on the same edge.
    config_in     = 1'b1;
    config_enable = 1'b1;
    config_commit = 1'b1;
    @(posedge config_clock);
    #1;
    config_enable = 1'b0;
    config_commit = 1'b0;
    check("simul_dio", 32'(data_to_io), SHADOW ? 32'h4 : 32'h0);
    check("simul_loaded", 32'(config_loaded), SHADOW ? 32'd0 : 32'd1);
    check("simul_error", 32'(config_error), SHADOW ? 32'd1 : 32'd0);
    for (int i = 0; i < 48; i++) shift(1'b0);
    check("simul_49", 32'(config_loaded), SHADOW ? 32'd0 : 32'd1);
    shift(1'b0);
    check("simul_50", 32'(config_loaded), 32'd1);

    // Chain pass-through of 0xA5 repeated, 50-cycle latency.
    pat = 8'hA5;
    for (int k = 0; k < 100; k++) pb[k] = pat[7 - (k % 8)];
    for (int k = 1; k <= 100; k++) begin
      shift(pb[k-1]);
      if (k >= 50) check($sformatf("chain_%0d", k), 32'(config_out), 32'(pb[k-50]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
